// File: rtl/int_sequencer.sv
// Interrupt/return sequencer: qualifies mip&mie under MIE, waits for a clean boundary, then strobes the CSR file and redirects fetch.
// Optional feature macro: INT_VECTORED_EN (vectored trap target when mtvec[1:0]==2'b01).
//
// state | meaning
// IDLE  | no trap in progress; watches mret_commit and the qualified request
// ARM   | request pending, commit held until a clean instruction boundary
// TAKE  | one-cycle interrupt strobe, flush and redirect to the trap target
// RET   | one-cycle return strobe, flush and redirect to mepc
module int_sequencer #(
  parameter int MEI_CODE = 11,
  parameter int MSI_CODE = 3,
  parameter int MTI_CODE = 7,
  parameter int NEST_W   = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       mip,
  input  logic [31:0]       mie,
  input  logic              MIE,
  input  logic [31:0]       mtvec,
  input  logic [31:0]       mepc,
  input  logic              boundary_valid,
  input  logic [31:0]       boundary_pc,
  input  logic              csr_wr_commit,
  input  logic              mret_commit,
  output logic              commit_hold,
  output logic              int_action,
  output logic              ret_action,
  output logic              hw_int,
  output logic [4:0]        int_code,
  output logic [31:0]       current_pc,
  output logic              flush,
  output logic              pc_redirect,
  output logic [31:0]       redirect_pc,
  output logic [NEST_W-1:0] nest_depth
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_TAKE, S_RET} state_t;

  state_t            state_q, state_d;
  logic [4:0]        code_q, code_d, win_code;
  logic [31:0]       pc_q, pc_d, tgt_q, tgt_d, trap_tgt, pend;
  logic [NEST_W-1:0] nest_q, nest_d;
  logic              req, take_st, ret_st;

  assign pend = mip & mie & 32'h0000_0888;
  assign req  = MIE & (|pend);

  always_comb begin
    win_code = 5'(MTI_CODE);
    if (pend[11])     win_code = 5'(MEI_CODE);
    else if (pend[3]) win_code = 5'(MSI_CODE);
  end

`ifdef INT_VECTORED_EN
  assign trap_tgt = (mtvec[1:0] == 2'b01) ? ({mtvec[31:2], 2'b00} + {25'd0, win_code, 2'b00})
                                          : {mtvec[31:2], 2'b00};
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec[1:0];
  assign trap_tgt = {mtvec[31:2], 2'b00};
`endif

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    nest_d  = nest_q;
    case (state_q)
      S_IDLE: begin
        // mret wins over a simultaneous request; the request is re-seen once MIE is restored
        if (mret_commit) begin
          state_d = S_RET;
          tgt_d   = mepc;
          if (nest_q != '0) nest_d = nest_q - 1'b1;
        end else if (req) begin
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (boundary_valid && !csr_wr_commit) begin
          state_d = S_TAKE;
          code_d  = win_code;
          pc_d    = boundary_pc;
          tgt_d   = trap_tgt;
          if (nest_q != '1) nest_d = nest_q + 1'b1;
        end
      end
      S_TAKE:  state_d = S_IDLE;
      S_RET:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      pc_q    <= '0;
      tgt_q   <= '0;
      nest_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      nest_q  <= nest_d;
    end
  end

  assign take_st     = (state_q == S_TAKE);
  assign ret_st      = (state_q == S_RET);
  assign commit_hold = (state_q == S_ARM) || take_st;
  assign int_action  = take_st;
  assign hw_int      = take_st;
  assign ret_action  = ret_st;
  assign flush       = take_st || ret_st;
  assign pc_redirect = take_st || ret_st;
  assign int_code    = take_st ? code_q : 5'd0;
  assign current_pc  = take_st ? pc_q : 32'd0;
  assign redirect_pc = (take_st || ret_st) ? tgt_q : 32'd0;
  assign nest_depth  = nest_q;

endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench for int_sequencer: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level expected-output model.
module tb_int_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] mip, mie, mtvec, mepc, boundary_pc;
  logic        MIE, boundary_valid, csr_wr_commit, mret_commit;
  logic        commit_hold, int_action, ret_action, hw_int, flush, pc_redirect;
  logic [4:0]  int_code;
  logic [31:0] current_pc, redirect_pc;
  logic [2:0]  nest_depth;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  int_sequencer dut (
    .clk(clk), .reset_n(reset_n), .mip(mip), .mie(mie), .MIE(MIE),
    .mtvec(mtvec), .mepc(mepc), .boundary_valid(boundary_valid),
    .boundary_pc(boundary_pc), .csr_wr_commit(csr_wr_commit), .mret_commit(mret_commit),
    .commit_hold(commit_hold), .int_action(int_action), .ret_action(ret_action),
    .hw_int(hw_int), .int_code(int_code), .current_pc(current_pc), .flush(flush),
    .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .nest_depth(nest_depth)
  );

  typedef struct packed {
    logic        commit_hold;
    logic        int_action;
    logic        ret_action;
    logic        hw_int;
    logic [4:0]  int_code;
    logic [31:0] current_pc;
    logic        flush;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  nest_depth;
  } obs_t;

  typedef struct packed {
    logic waiting;
    obs_t o;
  } mstate_t;

  obs_t    act;
  mstate_t m_q;

  assign act = {commit_hold, int_action, ret_action, hw_int, int_code, current_pc,
                flush, pc_redirect, redirect_pc, nest_depth};

  function automatic logic [4:0] winner(logic [31:0] q);
    if (q[11]) return 5'd11;
    if (q[3])  return 5'd3;
    return 5'd7;
  endfunction

  function automatic logic [31:0] trap_target(logic [31:0] tv, logic [4:0] code);
    logic [31:0] t;
    t = {tv[31:2], 2'b00};
`ifdef INT_VECTORED_EN
    if (tv[1:0] == 2'b01) t = t + 32'(code) * 4;
`endif
    return t;
  endfunction

  // Expected outputs of the next cycle, from the current expected outputs and the sampled inputs.
  function automatic mstate_t model_step(mstate_t cur);
    mstate_t     n;
    logic [31:0] q;
    logic        req;
    q   = mip & mie & 32'h888;
    req = MIE && (q != 0);
    n   = '0;
    n.o.nest_depth = cur.o.nest_depth;
    if (cur.o.int_action || cur.o.ret_action) begin
      n = n;
    end else if (!cur.waiting) begin
      if (mret_commit) begin
        n.o.ret_action  = 1'b1;
        n.o.flush       = 1'b1;
        n.o.pc_redirect = 1'b1;
        n.o.redirect_pc = mepc;
        n.o.nest_depth  = (cur.o.nest_depth == 0) ? 3'd0 : cur.o.nest_depth - 3'd1;
      end else if (req) begin
        n.waiting       = 1'b1;
        n.o.commit_hold = 1'b1;
      end
    end else if (req) begin
      n.o.commit_hold = 1'b1;
      if (boundary_valid && !csr_wr_commit) begin
        n.o.int_action  = 1'b1;
        n.o.hw_int      = 1'b1;
        n.o.int_code    = winner(q);
        n.o.current_pc  = boundary_pc;
        n.o.flush       = 1'b1;
        n.o.pc_redirect = 1'b1;
        n.o.redirect_pc = trap_target(mtvec, winner(q));
        n.o.nest_depth  = (cur.o.nest_depth == 3'd7) ? 3'd7 : cur.o.nest_depth + 3'd1;
      end else begin
        n.waiting = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_q <= '0;
    else          m_q <= model_step(m_q);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  logic [31:0] vec_exp;

  initial begin
`ifdef INT_VECTORED_EN
    vec_exp = 32'h42C;
`else
    vec_exp = 32'h400;
`endif
    MIE = 1'b1; mip = 32'h80; mie = 32'h80; mtvec = 32'h400; mepc = 32'h0;
    boundary_valid = 1'b1; boundary_pc = 32'h100; csr_wr_commit = 1'b0; mret_commit = 1'b0;

    fork
      forever begin
        @(negedge clk);
        total++;
        if (act !== m_q.o) begin
          bad++;
          $display("FAIL cycle_compare t=%0t got=%h want=%h", $time, act, m_q.o);
        end
      end
    join_none

    repeat (2) cyc();
    mid();
    chk("rst_hold", 32'(commit_hold), 0);
    chk("rst_depth", 32'(nest_depth), 0);

    // timer take
    cyc(); reset_n = 1'b1;
    cyc(); mid();
    chk("timer_hold", 32'(commit_hold), 1);
    chk("timer_noact_in_arm", 32'(int_action), 0);
    cyc(); mid();
    chk("timer_act", 32'(int_action), 1);
    chk("timer_hw", 32'(hw_int), 1);
    chk("timer_code", 32'(int_code), 7);
    chk("timer_pc", current_pc, 32'h100);
    chk("timer_redir", redirect_pc, 32'h400);
    chk("timer_depth", 32'(nest_depth), 1);
    chk("timer_hold_take", 32'(commit_hold), 1);
    MIE = 1'b0;
    cyc(); mid();
    chk("take_one_wide", 32'(int_action), 0);
    chk("hold_drop_after_take", 32'(commit_hold), 0);

    // priority
    mip = 32'h888; mie = 32'h888; MIE = 1'b1;
    cyc(); cyc(); mid();
    chk("prio_mei", 32'(int_code), 11);
    chk("prio_depth2", 32'(nest_depth), 2);
    MIE = 1'b0;
    cyc(); mip = 32'h88; MIE = 1'b1;
    cyc(); cyc(); mid();
    chk("prio_msi", 32'(int_code), 3);
    MIE = 1'b0;
    cyc();

    // boundary deferral
    mip = 32'h80; mie = 32'h80; boundary_valid = 1'b0; MIE = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      cyc(); mid();
      chk("defer_hold", 32'(commit_hold), 1);
      chk("defer_noact", 32'(int_action), 0);
    end
    boundary_valid = 1'b1; csr_wr_commit = 1'b1;
    cyc(); mid();
    chk("defer_csr_noact", 32'(int_action), 0);
    csr_wr_commit = 1'b0;
    cyc(); mid();
    chk("defer_take", 32'(int_action), 1);
    chk("defer_depth4", 32'(nest_depth), 4);
    MIE = 1'b0;
    cyc();

    // request withdrawn during ARM
    boundary_valid = 1'b0; MIE = 1'b1;
    cyc(); mid();
    chk("drop_arm_hold", 32'(commit_hold), 1);
    mie = 32'h0;
    cyc(); mid();
    chk("drop_hold0", 32'(commit_hold), 0);
    chk("drop_noact", 32'(int_action), 0);
    cyc(); mid();
    chk("drop_noact2", 32'(int_action), 0);

    // vectored / direct target for MEI
    mip = 32'h800; mie = 32'h800; mtvec = 32'h401; boundary_valid = 1'b1;
    cyc(); cyc(); mid();
    chk("vec_redir", redirect_pc, vec_exp);
    chk("vec_code", 32'(int_code), 11);
    MIE = 1'b0; mtvec = 32'h400;
    cyc();

    // reset while in ARM
    mip = 32'h80; mie = 32'h80; boundary_valid = 1'b0; MIE = 1'b1;
    cyc(); mid();
    chk("rarm_hold", 32'(commit_hold), 1);
    reset_n = 1'b0;
    #1;
    chk("rarm_hold0", 32'(commit_hold), 0);
    chk("rarm_depth0", 32'(nest_depth), 0);
    chk("rarm_flush0", 32'(flush), 0);
    boundary_valid = 1'b1;
    cyc(); reset_n = 1'b1;
    cyc(); mid();
    chk("no_stale_take", 32'(int_action), 0);
    chk("rearm_hold", 32'(commit_hold), 1);
    cyc(); mid();
    chk("retake_act", 32'(int_action), 1);
    chk("retake_depth", 32'(nest_depth), 1);
    MIE = 1'b0;
    cyc();

    // mret collides with a request in IDLE
    mepc = 32'h104; MIE = 1'b1; mret_commit = 1'b1;
    cyc(); mret_commit = 1'b0; mid();
    chk("ret_act", 32'(ret_action), 1);
    chk("ret_noint", 32'(int_action), 0);
    chk("ret_redir", redirect_pc, 32'h104);
    chk("ret_depth0", 32'(nest_depth), 0);
    cyc(); cyc(); cyc(); mid();
    chk("take_after_ret", 32'(int_action), 1);
    MIE = 1'b0;
    cyc();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      MIE            = ($urandom_range(9) < 7);
      mip            = ($urandom() & 32'hFFFF_F777) | ($urandom() & 32'h888);
      mie            = $urandom();
      mtvec          = $urandom();
      mepc           = $urandom();
      boundary_pc    = $urandom();
      boundary_valid = $urandom_range(1);
      csr_wr_commit  = ($urandom_range(4) == 0);
      mret_commit    = ($urandom_range(19) == 0);
      reset_n        = ($urandom_range(499) != 0);
      cyc();
    end
    reset_n = 1'b1;
    cyc(); mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/int_sequencer.md
# int_sequencer

Interrupt/return sequencer for the machine-mode CSR register file. It qualifies pending interrupts (`mip & mie`, gated by global `MIE`) and resolves priority. It holds the commit stage until a clean instruction boundary, then issues the one-cycle `int_action`/`ret_action` strobes, `int_code`/`hw_int` and `current_pc` to the CSR file, and it flushes and redirects the PC. It sits between the CSR file, the commit stage and the PC-select mux.

## Interface
Parameters:
- `MEI_CODE`, 11: cause code for external interrupt (`mip[11]`).
- `MSI_CODE`, 3: cause code for software interrupt (`mip[3]`).
- `MTI_CODE`, 7: cause code for timer interrupt (`mip[7]`).
- `NEST_W`, 3: width of the nesting-depth counter.

Ports:
- `clk`  in  1  core clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `mip`, `mie`  in  32  CSR file values.
- `MIE`  in  1  global interrupt enable (`mstatus.MIE`).
- `mtvec`, `mepc`  in  32  CSR file values.
- `boundary_valid`  in  1  commit stage is held at an instruction boundary and has no multi-cycle op in flight.
- `boundary_pc`  in  32  PC of the oldest unretired instruction.
- `csr_wr_commit`  in  1  a CSR write retires this cycle.
- `mret_commit`  in  1  an `mret` retires this cycle.
- `commit_hold`  out  1  blocks retirement.
- `int_action`, `ret_action`  out  1  one-cycle strobes to the CSR file.
- `hw_int`  out  1  mcause interrupt bit (always 1 with `int_action`).
- `int_code`  out  5  cause code.
- `current_pc`  out  32  EPC for the CSR file.
- `flush`  out  1  kill younger pipeline stages.
- `pc_redirect`  out  1  select `redirect_pc` at fetch.
- `redirect_pc`  out  32  redirect target.
- `nest_depth`  out  `NEST_W`  number of open handlers.

## Operation
- Qualified request: `req = MIE & |(mip & mie & 32'h888)`.
- Priority: MEI > MSI > MTI. The winner is recomputed every cycle until the decision.
- States:
  - IDLE: on `mret_commit` → RET. Otherwise, if `req` → ARM.
  - ARM: `commit_hold=1`.
    - If `req` drops → IDLE.
    - Else if `boundary_valid & ~csr_wr_commit` → TAKE. The winning code and `boundary_pc` are latched in the same cycle.
  - TAKE (1 cycle): `int_action=1`, `hw_int=1`, `int_code`=latched code, `current_pc`=latched PC, `flush=1`, `pc_redirect=1`, `redirect_pc`=trap target; `nest_depth` +1, saturating at max. → IDLE.
  - RET (1 cycle): `ret_action=1`, `flush=1`, `pc_redirect=1`, `redirect_pc=mepc`; `nest_depth` −1, saturating at 0. → IDLE.
- Trap target (direct mode): `{mtvec[31:2],2'b00}`.
- `int_action` and `ret_action` are never high together. No strobe is issued in a cycle where `csr_wr_commit` is high, so the CSR file never sees a mixed CSR-write/action code.
- `mret_commit` outside IDLE is a protocol violation: ignored in ARM, TAKE and RET.
- Simultaneous `mret_commit` and `req` in IDLE: RET wins. `req` is re-evaluated after `MIE` is restored.
- Nesting: a handler that re-enables `MIE` can be preempted normally; `nest_depth` tracks depth.

## Timing
- All outputs are registered or decoded from the state register. There is no combinational path from inputs to outputs.
- Reset value of every output is 0; state resets to IDLE and `nest_depth` to 0.
- `req` rising in cycle N: `commit_hold` is 1 in cycle N+1.
- Boundary accepted in cycle M (in ARM): TAKE strobes occur in cycle M+1, exactly one cycle wide, and the CSR file updates `mepc`/`mcause` at the end of M+1.
- `commit_hold` stays high through TAKE and drops in the cycle after TAKE.
- `mret_commit` in cycle N: RET strobes occur in cycle N+1.
- Minimum spacing between consecutive strobes is 2 cycles, because TAKE and RET always return to IDLE.
- Reset asserted in any state: outputs go to 0 immediately (asynchronous). A partially sequenced trap is discarded.

## Configuration
- `INT_VECTORED_EN` defined: when `mtvec[1:0]==2'b01`, the trap target is `{mtvec[31:2],2'b00} + 4*int_code`. When `mtvec[1:0]` is any other value, the trap target is the direct-mode target.
- `INT_VECTORED_EN` undefined: `mtvec[1:0]` is ignored and the trap target is always `{mtvec[31:2],2'b00}`.

## Test plan
- Timer take: `MIE=1`, `mie=mip=32'h80`, `boundary_valid` high from the ARM cycle, `boundary_pc=32'h100`, `mtvec=32'h400` → after reset release, `commit_hold` high; next cycle single-cycle `int_action`, `int_code=7`, `hw_int=1`, `current_pc=32'h100`, `redirect_pc=32'h400`, `nest_depth=1`.
- Priority: `mip=mie=32'h888` → `int_code=11`. Same with `mip=32'h88` → `int_code=3`.
- Boundary deferral: in ARM, hold `boundary_valid=0` for 5 cycles, then raise it with `csr_wr_commit=1` for 1 cycle → no strobe until the cycle after `csr_wr_commit` falls. Dropping `mie` during ARM → back to IDLE, `commit_hold=0`, no strobe.
- Return and collision: `mepc=32'h104`, `mret_commit` and `req` both high in IDLE → `ret_action` only, `redirect_pc=32'h104`, `nest_depth` back to 0. The interrupt is taken afterwards.
- Vectored mode (`INT_VECTORED_EN`): `mtvec=32'h401`, MEI → `redirect_pc=32'h42C`. Without the macro → `32'h400`.
- Reset mid-ARM: assert `reset_n=0` while `commit_hold=1` → all outputs 0 in the same cycle; after release, no stale TAKE strobe appears.
